tick_wdog: RTL and testbench
============================

Name: tick_wdog

Overview:
- Downstream consumer of the periodic delay-counter tick.
- Measures the cycle gap between consecutive `tick` pulses and checks each gap against the window [MIN_GAP, MAX_GAP].
- Counts good ticks and latches a sticky fault on an early tick, a late (missing) tick, or an upstream error.
- Sits between the tick generator and the system supervisor/interrupt logic.

Parameters:
- MIN_GAP, 200000, smallest legal gap in clk cycles.
- MAX_GAP, 200002, largest legal gap in clk cycles. Requires MIN_GAP <= MAX_GAP.
- GBITS, 18, gap counter width. Must hold MAX_GAP+1.
- TCW, 16, good-tick counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  monitor enable.
- tick  in  1  single-cycle pulse from upstream delay counter.
- up_err  in  1  upstream error flag; level, sampled every cycle.
- clr_fault  in  1  clears the sticky fault.
- ok  out  1  one-cycle pulse: in-window tick accepted.
- early  out  1  one-cycle pulse: tick arrived with gap < MIN_GAP.
- late  out  1  one-cycle pulse: no tick by gap == MAX_GAP.
- fault  out  1  high while in FAULT.
- tick_cnt  out  TCW  count of accepted ticks; wraps.

Behaviour:
- Outputs and reset:
  - All outputs are registered; a response appears the cycle after the causing input.
  - rst has top priority: state=IDLE, gap=0, tick_cnt=0, and ok/early/late/fault=0.
- Gap counter, active in SYNC/TRACK:
  - On tick: gap <= 1.
  - Otherwise: gap <= gap+1, saturating at MAX_GAP+1.
  - Definition: a tick at cycle t followed by a tick at cycle t+g sees gap == g at t+g.
  - In IDLE/FAULT: gap held at 0.
- IDLE:
  - en=1 → SYNC; tick_cnt cleared on this transition.
- SYNC (waiting for first tick, no window check):
  - en=0 → IDLE.
  - up_err → FAULT.
  - tick → TRACK. The first tick is not counted and does not pulse ok.
- TRACK, priority order top to bottom:
  - en=0 → IDLE.
  - up_err → FAULT.
  - tick with gap < MIN_GAP → early pulse, FAULT.
  - tick with MIN_GAP <= gap <= MAX_GAP → ok pulse, tick_cnt+1 (wraps to 0 at 2^TCW), stay in TRACK.
  - no tick and gap == MAX_GAP → late pulse, FAULT.
- FAULT:
  - Sticky; en, tick and up_err are ignored.
  - clr_fault=1 → SYNC if en=1, else IDLE.
  - fault drops the cycle after the transition.
- Simultaneous events:
  - tick and up_err together in TRACK → FAULT; no ok, no counting.
  - tick on the same cycle en falls → ignored, go to IDLE.
  - clr_fault outside FAULT has no effect.
- Reset mid-operation: state, counters and pulses are cleared immediately. The next monitoring run starts again from SYNC.
- Pulse exclusivity: at most one of ok/early/late is high in any cycle.

Optional Feature:
- Macro: TICK_WDOG_FLTCNT_EN.
- Defined:
  - Adds output flt_cnt [7:0]: count of entries into FAULT, saturating at 255.
  - Cleared only by rst; clr_fault does not clear it.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package tick_wdog_pkg contains:
  - state enum typedef {IDLE, SYNC, TRACK, FAULT};
  - default MIN_GAP/MAX_GAP/GBITS constants, matching the upstream N=200000 period (tick every 200001 cycles).
- One sub-module, tick_gap_cnt: saturating up-counter with synchronous load-to-1 and hold-at-0 controls, parameterised by GBITS and saturation value.

Test Plan (MIN_GAP=4, MAX_GAP=6, GBITS=4, TCW=8):
- en=1, ticks every 5 cycles ×10 → first tick enters TRACK; 9 ok pulses; tick_cnt=9; early/late/fault never asserted.
- In TRACK, tick 3 cycles after previous → early=1 for one cycle; fault=1 next cycle and stays high through further ticks; tick_cnt frozen.
- In TRACK, no tick for 6 cycles → late pulse one cycle after gap==6; fault=1; then clr_fault with en=1 → SYNC, fault=0, next ticks resume counting.
- Boundary gaps of exactly 4 and exactly 6 → both give ok; gap of 7 → late fires at gap 6, and a tick at 7 is ignored in FAULT.
- up_err and tick in the same TRACK cycle → fault, no ok. rst asserted mid-TRACK with tick_cnt=5 → tick_cnt=0, state IDLE, all outputs 0 the next cycle.
- With TICK_WDOG_FLTCNT_EN defined, 3 fault/clear cycles → flt_cnt=3. clr_fault leaves flt_cnt unchanged; rst clears it to 0.

Source files
------------

// File: rtl/tick_wdog_pkg.sv
// Shared types and default window constants for the tick watchdog.
// Defaults match an upstream N=200000 delay counter (one tick every 200001 cycles).
package tick_wdog_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        TRACK,
        FAULT
    } state_t;

    localparam int unsigned DEF_MIN_GAP = 200000;
    localparam int unsigned DEF_MAX_GAP = 200002;
    localparam int unsigned DEF_GBITS   = 18;
    localparam int unsigned DEF_TCW     = 16;

endpackage

// File: rtl/tick_gap_cnt.sv
// Saturating gap counter: hold clears to 0, load restarts at 1, otherwise
// counts up and stops at SAT.
module tick_gap_cnt #(
    parameter int unsigned GBITS = 18,
    parameter int unsigned SAT   = 200003
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    output logic [GBITS-1:0] cnt
);

    localparam logic [GBITS-1:0] SATV = GBITS'(SAT);

    always_ff @(posedge clk) begin
        if (rst || hold) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= GBITS'(1);
        end else if (cnt != SATV) begin
            cnt <= cnt + GBITS'(1);
        end
    end

endmodule

// File: rtl/tick_wdog.sv
// Tick watchdog: checks the gap between tick pulses against [MIN_GAP, MAX_GAP].
// Optional macro TICK_WDOG_FLTCNT_EN adds flt_cnt, a saturating count of FAULT entries.
module tick_wdog
    import tick_wdog_pkg::*;
#(
    parameter int unsigned MIN_GAP = DEF_MIN_GAP,
    parameter int unsigned MAX_GAP = DEF_MAX_GAP,
    parameter int unsigned GBITS   = DEF_GBITS,
    parameter int unsigned TCW     = DEF_TCW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           tick,
    input  logic           up_err,
    input  logic           clr_fault,
    output logic           ok,
    output logic           early,
    output logic           late,
    output logic           fault,
    output logic [TCW-1:0] tick_cnt
`ifdef TICK_WDOG_FLTCNT_EN
    ,
    output logic [7:0]     flt_cnt
`endif
);

    localparam logic [GBITS-1:0] MINV = GBITS'(MIN_GAP);
    localparam logic [GBITS-1:0] MAXV = GBITS'(MAX_GAP);

    state_t           state;
    state_t           state_nx;
    logic [GBITS-1:0] gap;
    logic             ok_d;
    logic             early_d;
    logic             late_d;

    tick_gap_cnt #(
        .GBITS (GBITS),
        .SAT   (MAX_GAP + 1)
    ) u_gap (
        .clk  (clk),
        .rst  (rst),
        .hold ((state == IDLE) || (state == FAULT)),
        .load (tick),
        .cnt  (gap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pulse decisions; en-low and up_err outrank any tick in the same cycle.
    always_comb begin
        ok_d    = 1'b0;
        early_d = 1'b0;
        late_d  = 1'b0;
        if (state == TRACK && en && !up_err) begin
            if (tick) begin
                if (gap < MINV) begin
                    early_d = 1'b1;
                end else begin
                    ok_d = 1'b1;
                end
            end else if (gap >= MAXV) begin
                late_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (en) state_nx = SYNC;
            end
            SYNC: begin
                if (!en)         state_nx = IDLE;
                else if (up_err) state_nx = FAULT;
                else if (tick)   state_nx = TRACK;
            end
            TRACK: begin
                if (!en)                   state_nx = IDLE;
                else if (up_err)           state_nx = FAULT;
                else if (early_d || late_d) state_nx = FAULT;
            end
            FAULT: begin
                if (clr_fault) state_nx = en ? SYNC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // fault mirrors the registered state, so it lags the early/late pulse by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ok       <= 1'b0;
            early    <= 1'b0;
            late     <= 1'b0;
            fault    <= 1'b0;
            tick_cnt <= '0;
        end else begin
            ok    <= ok_d;
            early <= early_d;
            late  <= late_d;
            fault <= (state == FAULT);
            if (state == IDLE && state_nx == SYNC) begin
                tick_cnt <= '0;
            end else if (ok_d) begin
                tick_cnt <= tick_cnt + TCW'(1);
            end
        end
    end

`ifdef TICK_WDOG_FLTCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt <= '0;
        end else if (state != FAULT && state_nx == FAULT && flt_cnt != 8'hFF) begin
            flt_cnt <= flt_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tick_wdog.sv
// Self-checking bench for tick_wdog (MIN_GAP=4, MAX_GAP=6, GBITS=4, TCW=8) with a
// cycle-count reference model; flt_cnt is checked when TICK_WDOG_FLTCNT_EN is defined.
module tb_tick_wdog;

    localparam int MIN = 4;
    localparam int MAX = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       up_err = 1'b0;
    logic       clr_fault = 1'b0;
    logic       ok, early, late, fault;
    logic [7:0] tick_cnt;
`ifdef TICK_WDOG_FLTCNT_EN
    logic [7:0] flt_cnt;
`endif

    tick_wdog #(
        .MIN_GAP (MIN),
        .MAX_GAP (MAX),
        .GBITS   (4),
        .TCW     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tick      (tick),
        .up_err    (up_err),
        .clr_fault (clr_fault),
        .ok        (ok),
        .early     (early),
        .late      (late),
        .fault     (fault),
        .tick_cnt  (tick_cnt)
`ifdef TICK_WDOG_FLTCNT_EN
        ,
        .flt_cnt   (flt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: monitoring run described by cycle numbers, not states.
    int         cyc = 0;
    bit         on = 0, seen = 0, flt = 0;
    int         last_t = 0;
    bit         m_ok = 0, m_early = 0, m_late = 0, m_fault = 0;
    logic [7:0] m_cnt = '0;
    int         m_fcnt = 0;

    logic [4:0] stim[$];

    task automatic model(input bit r, input bit e, input bit t, input bit u, input bit c);
        bit was_flt;
        int g;
        was_flt = flt;
        m_ok = 0; m_early = 0; m_late = 0;
        cyc++;
        if (r) begin
            on = 0; seen = 0; flt = 0; m_cnt = '0; m_fcnt = 0; m_fault = 0;
            return;
        end
        m_fault = was_flt;
        if (flt) begin
            if (c) begin flt = 0; on = e; seen = 0; end
        end else if (!on) begin
            if (e) begin on = 1; seen = 0; m_cnt = '0; end
        end else if (!e) begin
            on = 0;
        end else if (u) begin
            flt = 1; if (m_fcnt < 255) m_fcnt++;
        end else if (!seen) begin
            if (t) begin seen = 1; last_t = cyc; end
        end else begin
            g = cyc - last_t;
            if (t) begin
                if (g < MIN) begin
                    m_early = 1; flt = 1; if (m_fcnt < 255) m_fcnt++;
                end else begin
                    m_ok = 1; m_cnt = m_cnt + 8'd1; last_t = cyc;
                end
            end else if (g >= MAX) begin
                m_late = 1; flt = 1; if (m_fcnt < 255) m_fcnt++;
            end
        end
    endtask

    // One cycle: w = {rst, en, tick, up_err, clr_fault}; outputs are valid on return.
    task automatic step(input logic [4:0] w);
        {rst, en, tick, up_err, clr_fault} = w;
        model(w[4], w[3], w[2], w[1], w[0]);
        @(posedge clk);
        #1;
    endtask

    task automatic push_gap(input int g);
        for (int i = 1; i < g; i++) stim.push_back(5'b01000);
        stim.push_back(5'b01100);
    endtask

    task automatic test_reset;
        stim.delete();
        stim.push_back(5'b10000);
        stim.push_back(5'b11101);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            nvec++;
            if ({ok, early, late, fault, tick_cnt} !== 12'h000) begin
                nerr++;
                $display("FAIL reset: ok/early/late/fault=%b cnt=%0d, want 0000 cnt=0",
                         {ok, early, late, fault}, tick_cnt);
            end
        end
    endtask

    task automatic test_ok_run;
        int oks = 0;
        stim.delete();
        stim.push_back(5'b01000);
        push_gap(2);
        for (int k = 0; k < 9; k++) push_gap(5);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            oks += int'(ok);
            nvec++;
            if ({ok, early, late, fault} !== {m_ok, m_early, m_late, m_fault} || tick_cnt !== m_cnt) begin
                nerr++;
                $display("FAIL ok_run cyc %0d: oelf=%b cnt=%0d, want %b cnt=%0d", cyc,
                         {ok, early, late, fault}, tick_cnt, {m_ok, m_early, m_late, m_fault}, m_cnt);
            end
        end
        nvec++;
        if (oks != 9 || tick_cnt !== 8'd9 || fault !== 1'b0) begin
            nerr++;
            $display("FAIL ok_run_total: oks=%0d cnt=%0d fault=%b, want 9 9 0", oks, tick_cnt, fault);
        end
    endtask

    task automatic test_early;
        stim.delete();
        push_gap(3);
        push_gap(5);
        push_gap(5);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            nvec++;
            if ({ok, early, late, fault} !== {m_ok, m_early, m_late, m_fault} || tick_cnt !== m_cnt) begin
                nerr++;
                $display("FAIL early cyc %0d: oelf=%b cnt=%0d, want %b cnt=%0d", cyc,
                         {ok, early, late, fault}, tick_cnt, {m_ok, m_early, m_late, m_fault}, m_cnt);
            end
        end
        nvec++;
        if (fault !== 1'b1 || tick_cnt !== 8'd9) begin
            nerr++;
            $display("FAIL early_sticky: fault=%b cnt=%0d, want 1 9", fault, tick_cnt);
        end
    endtask

    task automatic test_late;
        int lates = 0;
        stim.delete();
        stim.push_back(5'b01001);
        push_gap(2);
        push_gap(5);
        push_gap(5);
        for (int i = 0; i < 8; i++) stim.push_back(5'b01000);
        stim.push_back(5'b01001);
        for (int i = 0; i < 3; i++) stim.push_back(5'b01000);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            lates += int'(late);
            nvec++;
            if ({ok, early, late, fault} !== {m_ok, m_early, m_late, m_fault} || tick_cnt !== m_cnt) begin
                nerr++;
                $display("FAIL late cyc %0d: oelf=%b cnt=%0d, want %b cnt=%0d", cyc,
                         {ok, early, late, fault}, tick_cnt, {m_ok, m_early, m_late, m_fault}, m_cnt);
            end
        end
        nvec++;
        if (lates != 1 || tick_cnt !== 8'd11 || fault !== 1'b0) begin
            nerr++;
            $display("FAIL late_total: lates=%0d cnt=%0d fault=%b, want 1 11 0", lates, tick_cnt, fault);
        end
    endtask

    task automatic test_boundary;
        int oks = 0, lates = 0;
        stim.delete();
        push_gap(1);
        push_gap(4);
        push_gap(6);
        push_gap(7);
        stim.push_back(5'b01001);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            oks += int'(ok);
            lates += int'(late);
            nvec++;
            if ({ok, early, late, fault} !== {m_ok, m_early, m_late, m_fault} || tick_cnt !== m_cnt) begin
                nerr++;
                $display("FAIL boundary cyc %0d: oelf=%b cnt=%0d, want %b cnt=%0d", cyc,
                         {ok, early, late, fault}, tick_cnt, {m_ok, m_early, m_late, m_fault}, m_cnt);
            end
        end
        nvec++;
        if (oks != 2 || lates != 1) begin
            nerr++;
            $display("FAIL boundary_total: oks=%0d lates=%0d, want 2 1", oks, lates);
        end
    endtask

    task automatic test_err_tick;
        stim.delete();
        push_gap(1);
        push_gap(5);
        for (int i = 1; i < 5; i++) stim.push_back(5'b01000);
        stim.push_back(5'b01110);
        stim.push_back(5'b01000);
        stim.push_back(5'b10000);
        stim.push_back(5'b01000);
        push_gap(1);
        push_gap(5);
        for (int i = 1; i < 5; i++) stim.push_back(5'b01000);
        stim.push_back(5'b00100);
        stim.push_back(5'b01000);
        push_gap(1);
        for (int k = 0; k < 5; k++) push_gap(5);
        stim.push_back(5'b01000);
        stim.push_back(5'b11100);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            nvec++;
            if ({ok, early, late, fault} !== {m_ok, m_early, m_late, m_fault} || tick_cnt !== m_cnt) begin
                nerr++;
                $display("FAIL err_tick cyc %0d: oelf=%b cnt=%0d, want %b cnt=%0d", cyc,
                         {ok, early, late, fault}, tick_cnt, {m_ok, m_early, m_late, m_fault}, m_cnt);
            end
        end
        nvec++;
        if ({ok, early, late, fault, tick_cnt} !== 12'h000) begin
            nerr++;
            $display("FAIL mid_reset: oelf=%b cnt=%0d, want 0000 cnt=0", {ok, early, late, fault}, tick_cnt);
        end
    endtask

    task automatic test_random;
        int to_tick;
        logic [4:0] w;
        to_tick = $urandom_range(8, 1);
        for (int i = 0; i < 3000; i++) begin
            w = 5'b01000;
            to_tick--;
            if (to_tick == 0) begin
                w[2] = 1'b1;
                to_tick = $urandom_range(8, 2);
            end
            if ($urandom_range(99, 0) == 0)  w[3] = 1'b0;
            if ($urandom_range(149, 0) == 0) w[1] = 1'b1;
            if ($urandom_range(7, 0) == 0)   w[0] = 1'b1;
            if ($urandom_range(499, 0) == 0) w[4] = 1'b1;
            step(w);
            nvec++;
            if ({ok, early, late, fault} !== {m_ok, m_early, m_late, m_fault} || tick_cnt !== m_cnt) begin
                nerr++;
                $display("FAIL random cyc %0d in=%b: oelf=%b cnt=%0d, want %b cnt=%0d", cyc, w,
                         {ok, early, late, fault}, tick_cnt, {m_ok, m_early, m_late, m_fault}, m_cnt);
            end
        end
    endtask

`ifdef TICK_WDOG_FLTCNT_EN
    task automatic test_fltcnt;
        stim.delete();
        stim.push_back(5'b10000);
        stim.push_back(5'b01000);
        for (int k = 0; k < 3; k++) begin
            push_gap(1);
            push_gap(2);
            stim.push_back(5'b01001);
        end
        stim.push_back(5'b01001);
        for (int i = 0; i < stim.size(); i++) begin
            step(stim[i]);
            nvec++;
            if (flt_cnt !== 8'(m_fcnt) || fault !== m_fault) begin
                nerr++;
                $display("FAIL fltcnt cyc %0d: flt_cnt=%0d fault=%b, want %0d %b",
                         cyc, flt_cnt, fault, m_fcnt, m_fault);
            end
        end
        nvec++;
        if (flt_cnt !== 8'd3) begin
            nerr++;
            $display("FAIL fltcnt_total: flt_cnt=%0d, want 3", flt_cnt);
        end
        step(5'b10000);
        nvec++;
        if (flt_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL fltcnt_reset: flt_cnt=%0d, want 0", flt_cnt);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ok_run();
        test_early();
        test_late();
        test_boundary();
        test_err_tick();
        test_random();
`ifdef TICK_WDOG_FLTCNT_EN
        test_fltcnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
